// File: rtl/rho_lane_rotator.sv
// -----------------------------------------------------------------------------
// rho_lane_rotator
//
// Rho-step engine for the Keccak-based encoder. One pass takes the 25 state
// lanes in order (index x+5y), rotates each by its fixed rho offset taken
// modulo LANE_W, and hands every rotated lane downstream. The rotation runs
// STEP bits per cycle while at least STEP bits remain, then one bit per cycle.
// The forward (encode) pass rotates left by r. The inverse (decode) pass
// rotates left by (LANE_W - r) mod LANE_W, which is a right rotation by r.
//
// Parameters:
//   LANE_W  lane width in bits (8, 16, 32 or 64)
//   STEP    bits rotated per bulk cycle (power of two, 1..LANE_W)
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin a 25-lane pass (sampled only while ready)
//   inverse           direction, latched when start is accepted
//   in_lane/in_valid/in_ready     lane input handshake
//   out_lane/out_valid/out_ready  rotated lane output handshake
//   lane_idx          index of the lane currently being processed
//   ready             block is idle and will accept start
//   done              one-cycle pulse after lane 24 has been handed off
//   cycle_cnt         (only with ROTATE_CYCLE_CNT_EN) busy cycles of the
//                     current/last pass, saturating at 16'hFFFF
//
// Optional feature macro: ROTATE_CYCLE_CNT_EN
// -----------------------------------------------------------------------------
module rho_lane_rotator #(
  parameter int LANE_W = 64,
  parameter int STEP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  input  logic [LANE_W-1:0] in_lane,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        lane_idx,
  output logic              ready,
  output logic              done
`ifdef ROTATE_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_cnt
`endif
);

  localparam int RW = $clog2(LANE_W);
  // STEP can equal LANE_W, so it is compared one bit wider than remaining.
  localparam logic [RW:0] STEP_X = (RW+1)'(STEP);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROT, S_OUT, S_DONE} state_t;

  state_t            state;
  logic [LANE_W-1:0] shreg;
  logic [RW-1:0]     remaining;
  logic              inv_q;

  logic [5:0]        offset;
  logic [RW-1:0]     r_fwd;
  logic [RW-1:0]     r_eff;
  logic [RW-1:0]     rem_next;
  logic [LANE_W-1:0] rot_next;

  function automatic logic [5:0] rho_offset(input logic [4:0] idx);
    case (idx)
      5'd0:  return 6'd0;
      5'd1:  return 6'd1;
      5'd2:  return 6'd62;
      5'd3:  return 6'd28;
      5'd4:  return 6'd27;
      5'd5:  return 6'd36;
      5'd6:  return 6'd44;
      5'd7:  return 6'd6;
      5'd8:  return 6'd55;
      5'd9:  return 6'd20;
      5'd10: return 6'd3;
      5'd11: return 6'd10;
      5'd12: return 6'd43;
      5'd13: return 6'd25;
      5'd14: return 6'd39;
      5'd15: return 6'd41;
      5'd16: return 6'd45;
      5'd17: return 6'd15;
      5'd18: return 6'd21;
      5'd19: return 6'd8;
      5'd20: return 6'd18;
      5'd21: return 6'd2;
      5'd22: return 6'd61;
      5'd23: return 6'd56;
      5'd24: return 6'd14;
      default: return 6'd0;
    endcase
  endfunction

  // NOTE: every signal driven here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    offset = rho_offset(lane_idx);
    // LANE_W is a power of two, so "mod LANE_W" is just the low RW bits.
    r_fwd  = offset[RW-1:0];
    // Left-rotating by (LANE_W - r) mod LANE_W equals right-rotating by r;
    // the RW-bit wrap of 0 - r gives exactly that value, including r = 0.
    r_eff  = inv_q ? (RW'(0) - r_fwd) : r_fwd;

    if ({1'b0, remaining} >= STEP_X) begin
      rot_next = (shreg << STEP) | (shreg >> (LANE_W - STEP));
      rem_next = remaining - STEP_X[RW-1:0];
    end else begin
      rot_next = {shreg[LANE_W-2:0], shreg[LANE_W-1]};
      rem_next = remaining - RW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lane_idx  <= '0;
      shreg     <= '0;
      remaining <= '0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            inv_q    <= inverse;
            lane_idx <= '0;
            ready    <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (in_valid && in_ready) begin
            shreg     <= in_lane;
            remaining <= r_eff;
            in_ready  <= 1'b0;
            if (r_eff == '0) begin
              out_valid <= 1'b1;
              state     <= S_OUT;
            end else begin
              state     <= S_ROT;
            end
          end
        end

        S_ROT: begin
          shreg     <= rot_next;
          remaining <= rem_next;
          if (rem_next == '0) begin
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end

        S_OUT: begin
          // shreg is untouched here, so out_lane holds under back-pressure.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (lane_idx == 5'd24) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              lane_idx <= lane_idx + 5'd1;
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
          ready     <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_lane = shreg;

`ifdef ROTATE_CYCLE_CNT_EN
  // Counts every non-idle cycle of a pass and holds the total while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (start) cycle_cnt <= '0;
    end else if (cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rho_lane_rotator.sv
// -----------------------------------------------------------------------------
// tb_rho_lane_rotator
//
// Self-checking bench for rho_lane_rotator. Two instances: LANE_W=64/STEP=8
// and LANE_W=16/STEP=4. Drivers push the expected lane, index and rotate-cycle
// count into a queue as each lane is issued; negedge monitors pop and compare
// on every output handshake.
// -----------------------------------------------------------------------------
module tb_rho_lane_rotator;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    int          rot;
  } exp_t;

  int rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 64-bit instance
  logic        start, inverse, in_valid, in_ready, out_valid, out_ready;
  logic        ready, done;
  logic [63:0] in_lane, out_lane;
  logic [4:0]  lane_idx;
`ifdef ROTATE_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  // 16-bit instance
  logic        s_start, s_inverse, s_in_valid, s_in_ready, s_out_valid;
  logic        s_out_ready, s_ready, s_done;
  logic [15:0] s_in_lane, s_out_lane;
  logic [4:0]  s_lane_idx;
`ifdef ROTATE_CYCLE_CNT_EN
  logic [15:0] s_cycle_cnt;
`endif

  rho_lane_rotator #(.LANE_W(64), .STEP(8)) u_dut64 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .in_lane(in_lane), .in_valid(in_valid), .in_ready(in_ready),
    .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready),
    .lane_idx(lane_idx), .ready(ready), .done(done)
`ifdef ROTATE_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  rho_lane_rotator #(.LANE_W(16), .STEP(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(s_start), .inverse(s_inverse),
    .in_lane(s_in_lane), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_lane(s_out_lane), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .lane_idx(s_lane_idx), .ready(s_ready), .done(s_done)
`ifdef ROTATE_CYCLE_CNT_EN
    , .cycle_cnt(s_cycle_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  exp_t        sb16[$];
  logic [63:0] lanes_in [25];
  logic [63:0] exp_data [25];
  int          exp_rot  [25];

  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int done16_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference rotation written bit by bit: bit b moves to (b + amt) mod w.
  function automatic logic [63:0] model_rot(input logic [63:0] d, input int w, input int amt);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < w; b++) r[(b + amt) % w] = d[b];
    return r;
  endfunction

  task automatic fill_exp(input bit inv, input int w, input int step);
    for (int i = 0; i < 25; i++) begin
      int r, reff;
      r    = rho_tb[i] % w;
      reff = inv ? (w - r) % w : r;
      exp_data[i] = model_rot(lanes_in[i], w, reff);
      exp_rot[i]  = reff / step + reff % step;
    end
  endtask

  // ---------------------------------------------------------------- monitors
  int  rot_cnt = 0, meas_rot = 0;
  bit  tracking = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      tracking = 0;
    end else begin
      if (in_ready && out_valid) check("hs_exclusive", 64'(in_ready && out_valid), 64'd0);
      if (tracking) begin
        if (out_valid) begin
          meas_rot = rot_cnt;
          tracking = 0;
        end else begin
          rot_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        tracking = 1;
        rot_cnt  = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(lane_idx), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          check("out_lane", out_lane, e.data);
          check("lane_idx", 64'(lane_idx), 64'(e.idx));
          check("rot_cycles", 64'(meas_rot), 64'(e.rot));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_last", 64'(sb.size()), 64'd0);
      end
    end
  end

  int  rot16_cnt = 0, meas16_rot = 0;
  bit  tracking16 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      tracking16 = 0;
    end else begin
      if (tracking16) begin
        if (s_out_valid) begin
          meas16_rot = rot16_cnt;
          tracking16 = 0;
        end else begin
          rot16_cnt++;
        end
      end
      if (s_in_valid && s_in_ready) begin
        tracking16 = 1;
        rot16_cnt  = 0;
      end
      if (s_out_valid && s_out_ready) begin
        if (sb16.size() == 0) begin
          check("w16_unexpected_out", 64'(s_lane_idx), 64'hFFFF);
        end else begin
          e = sb16.pop_front();
          check("w16_out_lane", 64'(s_out_lane), e.data);
          check("w16_lane_idx", 64'(s_lane_idx), 64'(e.idx));
          check("w16_rot_cycles", 64'(meas16_rot), 64'(e.rot));
        end
      end
      if (s_done) done16_cnt++;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send_lane(input logic [63:0] d);
    int n = 0;
    in_lane  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_handshake_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_lane16(input logic [15:0] d);
    int n = 0;
    s_in_lane  = d;
    s_in_valid = 1'b1;
    @(negedge clk);
    while (!s_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("w16_in_handshake_timeout", 64'(s_in_ready), 64'd1);
    @(posedge clk);
    #1 s_in_valid = 1'b0;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx  = 5'(i);
    e.data = exp_data[i];
    e.rot  = exp_rot[i];
    sb.push_back(e);
  endtask

  task automatic begin_pass(input logic inv);
    @(negedge clk);
    start   = 1'b1;
    inverse = inv;
    @(posedge clk);
    start_cyc = cyc;
    #1 start = 1'b0;
    check("lane_idx_at_start", 64'(lane_idx), 64'd0);
    check("in_ready_in_load", 64'(in_ready), 64'd1);
  endtask

  task automatic run_pass(input logic inv, input bit disturb);
    int d0 = done_cnt;
    int n = 0;
    begin_pass(inv);
    for (int i = 0; i < 25; i++) begin
      if (disturb && i == 10) begin
        // Stray start and a direction flip mid-pass must both be ignored.
        start   = 1'b1;
        inverse = ~inv;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
      end
      push_exp(i);
      send_lane(lanes_in[i]);
    end
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_pass", 64'(ready), 64'd1);
    check("done_count", 64'(done_cnt - d0), 64'd1);
`ifdef ROTATE_CYCLE_CNT_EN
    check("cycle_cnt", 64'(cycle_cnt), 64'(done_cyc - start_cyc));
`endif
  endtask

  // Stall lane 3 for 10 cycles; lane 3 of the all-ones forward pass is 1<<28.
  task automatic backpressure_lane3();
    int n = 0;
    @(posedge clk);
    #1;
    while (!(out_valid && lane_idx == 5'd3) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_reached", 64'(out_valid && lane_idx == 5'd3), 64'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_lane", out_lane, 64'h0000_0000_1000_0000);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_lane_idx", 64'(lane_idx), 64'd3);
    end
    out_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_lane"}, out_lane, 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_lane_idx"}, 64'(lane_idx), 64'd0);
`ifdef ROTATE_CYCLE_CNT_EN
    check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
`endif
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0; inverse = 1'b0; in_lane = '0; in_valid = 1'b0; out_ready = 1'b1;
    s_start = 1'b0; s_inverse = 1'b0; s_in_lane = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("w16_reset_ready", 64'(s_ready), 64'd1);
    check("w16_reset_out_valid", 64'(s_out_valid), 64'd0);
    #1 rst = 1'b0;

    // Forward pass, every lane 1, stall on lane 3, stray start at lane 10.
    for (int i = 0; i < 25; i++) lanes_in[i] = 64'h1;
    fill_exp(1'b0, 64, 8);
    exp_data[0] = 64'h1;                   exp_rot[0] = 0;
    exp_data[1] = 64'h2;                   exp_rot[1] = 1;
    exp_data[2] = 64'h4000_0000_0000_0000; exp_rot[2] = 13;
    fork
      run_pass(1'b0, 1'b1);
      backpressure_lane3();
    join

    // Inverse pass: lane 1 has r_eff = 63.
    fill_exp(1'b1, 64, 8);
    exp_data[1] = 64'h8000_0000_0000_0000; exp_rot[1] = 14;
    run_pass(1'b1, 1'b0);

    // Forward pass with distinct data per lane.
    for (int i = 0; i < 25; i++)
      lanes_in[i] = 64'hF0E1_D2C3_B4A5_9687 ^ (64'(i + 1) << (2 * i));
    fill_exp(1'b0, 64, 8);
    run_pass(1'b0, 1'b0);

    // Reset while lane 7 (r = 6, six single-bit ROT cycles) is rotating.
    d0 = done_cnt;
    begin_pass(1'b0);
    for (int i = 0; i < 7; i++) begin
      push_exp(i);
      send_lane(lanes_in[i]);
    end
    send_lane(lanes_in[7]);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_lane_idx", 64'(lane_idx), 64'd7);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrot_reset");
    sb.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_partial_done", 64'(done_cnt - d0), 64'd0);

    // Restart after reset: inverse pass over the distinct data.
    fill_exp(1'b1, 64, 8);
    run_pass(1'b1, 1'b0);

    // 16-bit / STEP 4 instance: lane 2 rotates by 14 in 5 cycles.
    for (int i = 0; i < 25; i++) lanes_in[i] = 64'h1;
    fill_exp(1'b0, 16, 4);
    exp_data[2] = 64'h4000; exp_rot[2] = 5;
    d0 = done16_cnt;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      exp_t e;
      e.idx  = 5'(i);
      e.data = exp_data[i];
      e.rot  = exp_rot[i];
      sb16.push_back(e);
      send_lane16(lanes_in[i][15:0]);
    end
    begin
      int n = 0;
      while (!s_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    check("w16_ready_after_pass", 64'(s_ready), 64'd1);
    check("w16_done_count", 64'(done16_cnt - d0), 64'd1);
    check("w16_queue_drained", 64'(sb16.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
